// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and constants for the multi-channel frequency meter
package freq_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // edge_mode encoding
  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_BOTH = 1'b1;

  // Saturation value of a w-bit counter
  function automatic logic [31:0] cnt_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/freq_meter_ch.sv
// rtl/freq_meter_ch.sv - one measured channel: synchroniser, edge detect, saturating counter, result
module freq_meter_ch
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             edge_mode,
  input  logic             meas,
  input  logic             last,
  output logic [CNT_W-1:0] result,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf_int;
  logic                   edge_det;
  logic                   sat;

  // hist holds the previous synchronised sample, so an edge is seen one cycle after the last sync flop changes
  assign edge_det = (edge_mode == EDGE_RISE) ? (sync[SYNC_STAGES-1] & ~hist)
                                             : (sync[SYNC_STAGES-1] ^ hist);
  assign sat      = (cnt == CNT_MAX);

  // Synchroniser chain and edge-history flop; free running regardless of window state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  // Count within the window; on the last cycle publish (including that cycle's edge) and clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      ovf_int <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
    end else if (!meas) begin
      cnt     <= '0;
      ovf_int <= 1'b0;
    end else if (last) begin
      result  <= (edge_det && !sat) ? cnt + 1'b1 : cnt;
      ovf     <= ovf_int | (edge_det & sat);
      cnt     <= '0;
      ovf_int <= 1'b0;
    end else if (edge_det) begin
      if (sat) ovf_int <= 1'b1;
      else     cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/freq_meter_mc.sv
// rtl/freq_meter_mc.sv - multi-channel frequency meter: window FSM, gate timer, readout mux
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              edge_mode,
  input  logic              cont,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_count,
  output logic [NUM_CH-1:0] ovf
);

  state_t            state;
  logic [GATE_W-1:0] timer;
  logic [GATE_W-1:0] len_m1;
  logic              mode_q;
  logic              meas;
  logic              last;
  logic [CNT_W-1:0]  res [NUM_CH];

  // gate_len of 0 behaves as a one-cycle window
  assign len_m1 = (gate_len == '0) ? '0 : gate_len - 1'b1;
  // Dropping ena stops counting and publishing in the same cycle it is seen
  assign meas   = ena && (state == MEAS);
  assign last   = meas && (timer == '0);

  // Window FSM with gate timer; window start latches length and edge mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      mode_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!ena) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start || cont) begin
              state  <= MEAS;
              busy   <= 1'b1;
              timer  <= len_m1;
              mode_q <= edge_mode;
            end
          end
          MEAS: begin
            if (timer == '0) begin
              done <= 1'b1;
              if (cont) begin
                timer  <= len_m1;
                mode_q <= edge_mode;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    freq_meter_ch #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sig      (sig_in[i]),
      .edge_mode(mode_q),
      .meas     (meas),
      .last     (last),
      .result   (res[i]),
      .ovf      (ovf[i])
    );
  end

  // Readout mux; unpopulated channel selects read as zero
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == 3'(i)) rd_count = res[i];
    end
  end

endmodule

// File: tb/tb_freq_meter_mc.sv
// tb/tb_freq_meter_mc.sv - self-checking bench for freq_meter_mc
module tb_freq_meter_mc;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 5;
  localparam int GATE_W = 24;
  localparam int S      = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    int glen;
    bit mode;
    int per0;
    int per1;
    int exp_len;
    int exp_c0;
    int exp_o0;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst, ena, edge_mode, cont, start, busy, done;
  logic [NUM_CH-1:0] sig_in, ovf;
  logic [GATE_W-1:0] gate_len;
  logic [2:0]        rd_sel;
  logic [CNT_W-1:0]  rd_count;

  int                n_checks = 0;
  int                n_fail = 0;
  int                cyc = 0;
  int                gen_per [NUM_CH];
  logic [NUM_CH-1:0] pad_log [0:8191];
  int                last_cnt [NUM_CH];
  bit                last_ovf [NUM_CH];

  always #5 clk = ~clk;

  freq_meter_mc #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .sig_in(sig_in), .gate_len(gate_len),
    .edge_mode(edge_mode), .cont(cont), .start(start), .busy(busy), .done(done),
    .rd_sel(rd_sel), .rd_count(rd_count), .ovf(ovf)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: new pad values at negedge, log what the DUT samples at posedge
  task automatic step();
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (gen_per[c] < 0) sig_in[c] = 1'($urandom_range(0, 1));
      else if (gen_per[c] > 0 && (cyc % gen_per[c]) == 0) sig_in[c] = ~sig_in[c];
    end
    @(posedge clk);
    pad_log[cyc] = sig_in;
    cyc++;
    #1;
  endtask

  // Reference: window covers the L cycles after the start edge t; a pad change
  // reaches the counter S+1 clocks after it is sampled
  function automatic void model(input int t, input int L, input bit mode, input int ch,
                                output int cnt, output bit ov);
    int   raw;
    logic a, b;
    raw = 0;
    for (int e = t + 1; e <= t + L; e++) begin
      a = pad_log[e-S-1][ch];
      b = pad_log[e-S][ch];
      if (mode ? (a != b) : (!a && b)) raw++;
    end
    ov  = (raw > CMAX);
    cnt = ov ? CMAX : raw;
  endfunction

  task automatic start_window(input int glen, input bit mode, input bit use_cont, output int t);
    gate_len  = GATE_W'(glen);
    edge_mode = mode;
    if (use_cont) cont = 1'b1;
    else start = 1'b1;
    step();
    t     = cyc - 1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input int limit, output int de, output bit ok);
    ok = 1'b0;
    de = -1;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      if (done) begin
        ok = 1'b1;
        de = cyc - 1;
      end
    end
  endtask

  task automatic check_results(input int t, input int L, input bit mode);
    int m;
    bit mo;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      model(t, L, mode, ch, m, mo);
      rd_sel = 3'(ch);
      #1;
      check($sformatf("count_ch%0d", ch), int'(rd_count), m);
      check($sformatf("ovf_ch%0d", ch), int'(ovf[ch]), int'(mo));
      last_cnt[ch] = m;
      last_ovf[ch] = mo;
    end
  endtask

  task automatic finish_window(input int t, input int L, input bit mode, input bit single,
                               output int de);
    bit ok;
    wait_done(L + 6, de, ok);
    check("done_seen", int'(ok), 1);
    if (ok) begin
      check("done_latency", de - t, L);
      check("busy_at_done", int'(busy), single ? 0 : 1);
      check_results(t, L, mode);
    end
    if (single) begin
      step();
      check("done_single_pulse", int'(done), 0);
    end
  endtask

  initial begin
    vec_t vecs [12];
    int   t, de, sum, nd;

    rst = 1'b1; ena = 1'b1; cont = 1'b0; start = 1'b0; edge_mode = 1'b0;
    gate_len = '0; rd_sel = '0; sig_in = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      gen_per[c]  = 0;
      last_cnt[c] = 0;
      last_ovf[c] = 1'b0;
    end
    repeat (3) step();

    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovf", int'(ovf), 0);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rd_sel = 3'(ch);
      #1;
      check("rst_count", int'(rd_count), 0);
    end
    rst = 1'b0;
    repeat (5) step();

    vecs[0] = '{100, 1'b0, 5, 25, 100, -1, -1};
    vecs[1] = '{100, 1'b1, 5, 25, 100, -1, -1};
    vecs[2] = '{0,   1'b0, 3, 7,  1,   -1, -1};
    vecs[3] = '{1,   1'b1, 1, 2,  1,   -1, -1};
    vecs[4] = '{100, 1'b1, 2, 0,  100, CMAX, 1};
    vecs[5] = '{100, 1'b1, 0, 0,  100, 0, 0};
    for (int i = 6; i < 12; i++) begin
      vecs[i].glen    = int'($urandom_range(0, 40));
      vecs[i].mode    = 1'($urandom_range(0, 1));
      vecs[i].per0    = int'($urandom_range(0, 8)) - 1;
      vecs[i].per1    = int'($urandom_range(0, 8)) - 1;
      vecs[i].exp_len = (vecs[i].glen == 0) ? 1 : vecs[i].glen;
      vecs[i].exp_c0  = -1;
      vecs[i].exp_o0  = -1;
    end

    for (int i = 0; i < 12; i++) begin
      gen_per[0] = vecs[i].per0;
      gen_per[1] = vecs[i].per1;
      repeat (6) step();
      start_window(vecs[i].glen, vecs[i].mode, 1'b0, t);
      // mode and length must be held from window start
      edge_mode = ~edge_mode;
      gate_len  = GATE_W'(7);
      finish_window(t, vecs[i].exp_len, vecs[i].mode, 1'b1, de);
      if (vecs[i].exp_c0 >= 0) begin
        rd_sel = 3'd0;
        #1;
        check("vec_fixed_count0", int'(rd_count), vecs[i].exp_c0);
        check("vec_fixed_ovf0", int'(ovf[0]), vecs[i].exp_o0);
      end
    end

    for (int s = NUM_CH; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      check("rd_sel_out_of_range", int'(rd_count), 0);
    end

    // Continuous mode: four back-to-back windows
    gen_per[0] = 5;
    gen_per[1] = -1;
    repeat (6) step();
    start_window(50, 1'b0, 1'b1, t);
    sum = 0;
    for (int w = 0; w < 4; w++) begin
      finish_window(t, 50, 1'b0, (w == 3), de);
      sum += last_cnt[0];
      if (de < 0) break;
      t = de;
      if (w == 2) cont = 1'b0;
    end
    cont = 1'b0;
    check("cont_sum_rising", sum, 20);

    // Asynchronous reset mid-window
    gen_per[0] = 3;
    gen_per[1] = 7;
    repeat (6) step();
    start_window(100, 1'b1, 1'b0, t);
    repeat (30) step();
    rst = 1'b1;
    #1;
    check("rst_abort_busy", int'(busy), 0);
    check("rst_abort_ovf", int'(ovf), 0);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rd_sel = 3'(ch);
      #1;
      check("rst_abort_count", int'(rd_count), 0);
    end
    #1;
    rst = 1'b0;
    nd = 0;
    repeat (120) begin
      step();
      if (done) nd++;
    end
    check("rst_abort_no_done", nd, 0);

    // ena abort: previous results must survive
    repeat (6) step();
    start_window(60, 1'b0, 1'b0, t);
    finish_window(t, 60, 1'b0, 1'b1, de);
    start_window(100, 1'b0, 1'b0, t);
    repeat (30) step();
    ena = 1'b0;
    step();
    check("ena_abort_busy", int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored_when_disabled", int'(busy), 0);
    ena = 1'b1;
    nd = 0;
    repeat (120) begin
      step();
      if (done) nd++;
    end
    check("ena_abort_no_done", nd, 0);
    check("ena_abort_idle", int'(busy), 0);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rd_sel = 3'(ch);
      #1;
      check("ena_abort_count_held", int'(rd_count), last_cnt[ch]);
      check("ena_abort_ovf_held", int'(ovf[ch]), int'(last_ovf[ch]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
